// File: rtl/result_ram_writer.sv
// result_ram_writer
// Writer end of the per-line results memory. Stores a valid/ready stream of
// WIDTH-bit results at consecutive addresses and exposes a registered read
// port with the same one-cycle timing as the results ROM, so a downstream
// accumulator can read computed results in place of the precomputed table.
//
// Optional feature: define WR_CHECKSUM_EN to add the `checksum` output, the
// running sum of every accepted word.
//
// state  | meaning
// S_FILL | accepting words; in_ready while fewer than DEPTH words stored
// S_DONE | frame complete (last word or memory full); contents stable
module result_ram_writer #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 200,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    input  logic              in_last,
    output logic [ADDR_W-1:0] wr_addr_gray,
    output logic [ADDR_W:0]   count,
    output logic              done,
    output logic              overflow,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
`ifdef WR_CHECKSUM_EN
    ,
    output logic [WIDTH+ADDR_W-1:0] checksum
`endif
);

    typedef enum logic {S_FILL = 1'b0, S_DONE = 1'b1} state_t;

    localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W:0]   count_inc;
    logic              accept;
    logic              frame_end;
    logic              ended_by_last;
    logic [WIDTH-1:0]  mem [DEPTH];

    assign accept       = in_valid && in_ready;
    assign count_inc    = count + (ADDR_W + 1)'(1);
    assign frame_end    = accept && (in_last || (count_inc == DEPTH_C));
    assign wr_addr_gray = wr_ptr ^ (wr_ptr >> 1);

    // State register; clear restarts the fill just like reset
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state_q <= S_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: leave FILL on the word that ends the frame
    always_comb begin
        state_d = state_q;
        if (state_q == S_FILL && frame_end) begin
            state_d = S_DONE;
        end
    end

    // Outputs decoded from state and fill level
    always_comb begin
        in_ready = 1'b0;
        done     = 1'b0;
        case (state_q)
            S_FILL: in_ready = (count < DEPTH_C);
            S_DONE: done     = 1'b1;
            default: begin
                in_ready = 1'b0;
                done     = 1'b0;
            end
        endcase
    end

    // Write pointer, fill count and overflow tracking.
    // The pointer saturates at DEPTH-1 so it never leaves the Gray-coded range;
    // the DEPTH-th word is still written there and ends the frame.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr        <= '0;
            count         <= '0;
            ended_by_last <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            if (accept) begin
                count <= count_inc;
                if (wr_ptr != LAST_ADDR) begin
                    wr_ptr <= wr_ptr + ADDR_W'(1);
                end
            end
            if (frame_end) begin
                ended_by_last <= in_last;
            end
            // A frame closed by in_last ignores later offers; a frame that
            // merely filled up flags them as lost
            if (state_q == S_DONE && in_valid && !ended_by_last) begin
                overflow <= 1'b1;
            end
        end
    end

    // Write port; a word coinciding with clear or reset is dropped
    always_ff @(posedge clk) begin
        if (accept && !rst && !clear) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // Registered read port, read-before-write on a same-address collision
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

`ifdef WR_CHECKSUM_EN
    // Running sum of accepted words, widened so DEPTH words cannot overflow
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            checksum <= '0;
        end else if (accept) begin
            checksum <= checksum + (WIDTH + ADDR_W)'(in_data);
        end
    end
`endif

endmodule

// File: tb/tb_result_ram_writer.sv
// Self-checking bench for result_ram_writer: directed frames, read-back through
// a scoreboard queue popped by an independent read-port monitor.
module tb_result_ram_writer;

    localparam int WIDTH  = 32;
    localparam int DEPTH  = 200;
    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              clear;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_data;
    logic              in_last;
    logic [ADDR_W-1:0] wr_addr_gray;
    logic [ADDR_W:0]   count;
    logic              done;
    logic              overflow;
    logic [ADDR_W-1:0] rd_addr;
    logic [WIDTH-1:0]  rd_data;
`ifdef WR_CHECKSUM_EN
    logic [WIDTH+ADDR_W-1:0] checksum;
`endif

    int checks   = 0;
    int failures = 0;

    logic [WIDTH-1:0] exp_q[$];
    logic             rd_issued = 1'b0;
    logic             rd_pend   = 1'b0;

    always #5 clk = ~clk;

    result_ram_writer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .wr_addr_gray (wr_addr_gray),
        .count        (count),
        .done         (done),
        .overflow     (overflow),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data)
`ifdef WR_CHECKSUM_EN
        ,
        .checksum     (checksum)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Read monitor: a read issued in one cycle shows on rd_data after the next edge
    always @(posedge clk) rd_pend <= rd_issued;

    always @(negedge clk) begin
        if (rd_pend) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rd_scoreboard: read data 0x%0h with no expected entry", rd_data);
            end else begin
                chk("rd_data", 64'(rd_data), 64'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] exp);
        rd_addr   = a;
        rd_issued = 1'b1;
        exp_q.push_back(exp);
        tick();
        rd_issued = 1'b0;
    endtask

    task automatic send(input logic [WIDTH-1:0] d, input logic last);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        if (n == 20) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: in_ready=0 after %0d cycles, required 1", n);
        end
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic do_clear;
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; rd_addr = '0;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_gray", 64'(wr_addr_gray), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd1);
        chk("rst_rd_data", 64'(rd_data), 64'd0);

        // Five words 1..5, last on 5
        for (int i = 1; i <= 5; i++) send(WIDTH'(i), i == 5);
        chk("f5_count", 64'(count), 64'd5);
        chk("f5_done", 64'(done), 64'd1);
        chk("f5_gray", 64'(wr_addr_gray), 64'h07);
        chk("f5_ready", 64'(in_ready), 64'd0);
        for (int i = 0; i < 5; i++) rd(ADDR_W'(i), WIDTH'(i + 1));

        // clear coinciding with the 4th word drops it
        do_clear();
        chk("clr_done", 64'(done), 64'd0);
        send(32'hA0, 1'b0);
        send(32'hA1, 1'b0);
        send(32'hA2, 1'b0);
        chk("pre_clr_gray", 64'(wr_addr_gray), 64'h02);
        in_valid = 1'b1; in_data = 32'hA3; clear = 1'b1;
        tick();
        in_valid = 1'b0; clear = 1'b0;
        chk("clr_acc_count", 64'(count), 64'd0);
        chk("clr_acc_gray", 64'(wr_addr_gray), 64'd0);
        chk("clr_acc_done", 64'(done), 64'd0);
        chk("clr_acc_overflow", 64'(overflow), 64'd0);
        rd(8'd3, 32'd4);
        rd(8'd0, 32'hA0);

        // Same-cycle read and write of address 2: old data first, new data next
        send(32'h21, 1'b0);
        send(32'h22, 1'b0);
        send(32'h11, 1'b0);
        do_clear();
        send(32'h21, 1'b0);
        send(32'h22, 1'b0);
        in_valid = 1'b1; in_data = 32'hDEADBEEF; in_last = 1'b1;
        rd_addr = 8'd2; rd_issued = 1'b1; exp_q.push_back(32'h11);
        tick();
        in_valid = 1'b0; in_last = 1'b0; rd_issued = 1'b0;
        rd(8'd2, 32'hDEADBEEF);

        // Frame closed by in_last, then stray valids: no overflow
        do_clear();
        send(32'h31, 1'b0);
        send(32'h32, 1'b0);
        send(32'h33, 1'b1);
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("last_ready_low", 64'(in_ready), 64'd0);
            tick();
        end
        in_valid = 1'b0;
        chk("last_count", 64'(count), 64'd3);
        chk("last_done", 64'(done), 64'd1);
        chk("last_overflow", 64'(overflow), 64'd0);

        // rst mid-frame abandons the frame
        do_clear();
        send(32'h41, 1'b0);
        send(32'h42, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_count", 64'(count), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);

        // Fill to DEPTH without last, then one extra word
        for (int i = 0; i < DEPTH; i++) send(WIDTH'(i), 1'b0);
        chk("full_ready", 64'(in_ready), 64'd0);
        chk("full_done", 64'(done), 64'd1);
        chk("full_count", 64'(count), 64'd200);
        chk("full_overflow_pre", 64'(overflow), 64'd0);
        in_valid = 1'b1; in_data = 32'hBAD;
        tick();
        in_valid = 1'b0;
        chk("full_overflow", 64'(overflow), 64'd1);
        chk("full_count_hold", 64'(count), 64'd200);
        rd(8'd199, 32'd199);
        rd(8'd0, 32'd0);
        rd(8'd100, 32'd100);

`ifdef WR_CHECKSUM_EN
        do_clear();
        send(32'hFFFFFFFF, 1'b0);
        send(32'hFFFFFFFF, 1'b0);
        send(32'hFFFFFFFF, 1'b1);
        chk("checksum_sum", 64'(checksum), 64'h2FFFFFFFD);
        do_clear();
        chk("checksum_clear", 64'(checksum), 64'd0);
`endif

        tick(); tick();
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
